// File: rtl/board_port_if.sv
// Board RAM port bundle: display, engine and editor requesters plus the RAM side.
// The arbiter takes the slave view, the requesters/RAM model take the master view.
interface board_port_if #(
    parameter int ADDR_W = 11
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_rvalid;
    logic              disp_rdata;

    logic              eng_req;
    logic              eng_we;
    logic              eng_lock;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_wdata;
    logic              eng_gnt;
    logic              eng_rvalid;
    logic              eng_rdata;
    logic              eng_starved;

    logic              ed_req;
    logic              ed_we;
    logic [ADDR_W-1:0] ed_addr;
    logic              ed_wdata;
    logic              ed_gnt;
    logic              ed_rvalid;
    logic              ed_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wdata;
    logic              mem_rdata;

    modport slave (
        input  disp_req, disp_addr,
        input  eng_req, eng_we, eng_lock, eng_addr, eng_wdata,
        input  ed_req, ed_we, ed_addr, ed_wdata,
        input  mem_rdata,
        output disp_rvalid, disp_rdata,
        output eng_gnt, eng_rvalid, eng_rdata, eng_starved,
        output ed_gnt, ed_rvalid, ed_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_req, disp_addr,
        output eng_req, eng_we, eng_lock, eng_addr, eng_wdata,
        output ed_req, ed_we, ed_addr, ed_wdata,
        output mem_rdata,
        input  disp_rvalid, disp_rdata,
        input  eng_gnt, eng_rvalid, eng_rdata, eng_starved,
        input  ed_gnt, ed_rvalid, ed_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/board_port_arbiter.sv
// Single-port board RAM arbiter: display first, then locked engine,
// then starved engine, then engine/editor round-robin.
module board_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int STARVE_LIM = 64
) (
    input logic clk,
    input logic rst_n,
    board_port_if.slave bus
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_DISP = 2'd1;
    localparam logic [1:0] OWN_ENG  = 2'd2;
    localparam logic [1:0] OWN_ED   = 2'd3;
    localparam logic [7:0] LIM      = 8'(STARVE_LIM);

    logic       rr_q, rr_d;
    logic       lock_q, lock_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] own_q, own_d;

    logic              starved;
    logic              eng_win;
    logic              ed_win;
    logic              rr_win;
    logic              en_c;
    logic              we_c;
    logic [ADDR_W-1:0] addr_c;
    logic              wdata_c;

    assign starved = (cnt_q >= LIM);

    // Grant resolution; rr_q=0 prefers the engine.
    always_comb begin
        eng_win = 1'b0;
        ed_win  = 1'b0;
        rr_win  = 1'b0;
        if (!bus.disp_req) begin
            if (lock_q && bus.eng_req) begin
                eng_win = 1'b1;
            end else if (starved && bus.eng_req) begin
                eng_win = 1'b1;
            end else if (bus.eng_req && bus.ed_req) begin
                rr_win  = 1'b1;
                eng_win = !rr_q;
                ed_win  = rr_q;
            end else if (bus.eng_req) begin
                rr_win  = 1'b1;
                eng_win = 1'b1;
            end else if (bus.ed_req) begin
                rr_win  = 1'b1;
                ed_win  = 1'b1;
            end
        end
    end

    always_comb begin
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = 1'b0;
        if (bus.disp_req) begin
            addr_c = bus.disp_addr;
        end else if (eng_win) begin
            we_c    = bus.eng_we;
            addr_c  = bus.eng_addr;
            wdata_c = bus.eng_wdata;
        end else if (ed_win) begin
            we_c    = bus.ed_we;
            addr_c  = bus.ed_addr;
            wdata_c = bus.ed_wdata;
        end
    end

    assign en_c = rst_n && (bus.disp_req || eng_win || ed_win);

    assign bus.mem_en    = en_c;
    assign bus.mem_we    = en_c && we_c;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;
    assign bus.eng_gnt   = rst_n && eng_win;
    assign bus.ed_gnt    = rst_n && ed_win;

    // A lock survives display cycles untouched and is re-evaluated on free ones.
    always_comb begin
        lock_d = bus.disp_req ? lock_q : (eng_win && bus.eng_lock);
        rr_d   = rr_win ? eng_win : rr_q;
        cnt_d  = cnt_q;
        if (eng_win) begin
            cnt_d = 8'd0;
        end else if (bus.eng_req && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
        own_d = OWN_NONE;
        if (!we_c) begin
            if (bus.disp_req) begin
                own_d = OWN_DISP;
            end else if (eng_win) begin
                own_d = OWN_ENG;
            end else if (ed_win) begin
                own_d = OWN_ED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q   <= 1'b0;
            lock_q <= 1'b0;
            cnt_q  <= 8'd0;
            own_q  <= OWN_NONE;
        end else begin
            rr_q   <= rr_d;
            lock_q <= lock_d;
            cnt_q  <= cnt_d;
            own_q  <= own_d;
        end
    end

    assign bus.disp_rvalid = (own_q == OWN_DISP);
    assign bus.eng_rvalid  = (own_q == OWN_ENG);
    assign bus.ed_rvalid   = (own_q == OWN_ED);
    assign bus.disp_rdata  = bus.mem_rdata;
    assign bus.eng_rdata   = bus.mem_rdata;
    assign bus.ed_rdata    = bus.mem_rdata;
    assign bus.eng_starved = starved;

endmodule

// File: tb/tb_board_port_arbiter.sv
// Directed bench for board_port_arbiter with a 2048x1 RAM model
// whose unwritten cells read back as the parity of their address.
module tb_board_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    board_port_if #(.ADDR_W(11)) bp ();

    board_port_arbiter #(
        .ADDR_W    (11),
        .STARVE_LIM(4)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bp)
    );

    bit [2047:0] wr_mask;
    bit [2047:0] wr_val;
    logic        rd_q;

    always @(posedge clk) begin
        if (bp.mem_en) begin
            if (bp.mem_we) begin
                wr_mask[bp.mem_addr] <= 1'b1;
                wr_val[bp.mem_addr]  <= bp.mem_wdata;
            end else begin
                rd_q <= wr_mask[bp.mem_addr] ? wr_val[bp.mem_addr] : ^bp.mem_addr;
            end
        end
    end

    assign bp.mem_rdata = rd_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv_disp(input logic req, input logic [10:0] addr);
        bp.disp_req  = req;
        bp.disp_addr = addr;
    endtask

    task automatic drv_eng(input logic req, input logic we, input logic lock,
                           input logic [10:0] addr, input logic wdata);
        bp.eng_req   = req;
        bp.eng_we    = we;
        bp.eng_lock  = lock;
        bp.eng_addr  = addr;
        bp.eng_wdata = wdata;
    endtask

    task automatic drv_ed(input logic req, input logic we,
                          input logic [10:0] addr, input logic wdata);
        bp.ed_req   = req;
        bp.ed_we    = we;
        bp.ed_addr  = addr;
        bp.ed_wdata = wdata;
    endtask

    task automatic do_reset();
        drv_disp(1'b0, 11'h0);
        drv_eng(1'b0, 1'b0, 1'b0, 11'h0, 1'b0);
        drv_ed(1'b0, 1'b0, 11'h0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with every requester active, then display priority on release
        rst_n = 1'b0;
        drv_disp(1'b1, 11'h040);
        drv_eng(1'b1, 1'b0, 1'b0, 11'h011, 1'b0);
        drv_ed(1'b1, 1'b0, 11'h007, 1'b0);
        tick();
        tick();
        check("rst_mem_en", bp.mem_en, 1'b0);
        check("rst_eng_gnt", bp.eng_gnt, 1'b0);
        check("rst_ed_gnt", bp.ed_gnt, 1'b0);
        check("rst_disp_rvalid", bp.disp_rvalid, 1'b0);
        check("rst_eng_rvalid", bp.eng_rvalid, 1'b0);
        check("rst_ed_rvalid", bp.ed_rvalid, 1'b0);
        check("rst_starved", bp.eng_starved, 1'b0);
        rst_n = 1'b1;
        #1;
        check("disp_mem_en", bp.mem_en, 1'b1);
        check("disp_mem_addr", bp.mem_addr, 11'h040);
        check("disp_mem_we", bp.mem_we, 1'b0);
        check("disp_eng_gnt", bp.eng_gnt, 1'b0);
        check("disp_ed_gnt", bp.ed_gnt, 1'b0);
        tick();
        check("disp_rvalid", bp.disp_rvalid, 1'b1);
        check("disp_rdata", bp.disp_rdata, 1'b1);
        check("disp_eng_rvalid", bp.eng_rvalid, 1'b0);

        // Round-robin between two continuous readers
        do_reset();
        drv_eng(1'b1, 1'b0, 1'b0, 11'h011, 1'b0);
        drv_ed(1'b1, 1'b0, 11'h007, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_eng_gnt", bp.eng_gnt, (i % 2) == 0);
            check("rr_ed_gnt", bp.ed_gnt, (i % 2) == 1);
            tick();
            check("rr_eng_rvalid", bp.eng_rvalid, (i % 2) == 0);
            check("rr_ed_rvalid", bp.ed_rvalid, (i % 2) == 1);
            check("rr_rdata", bp.ed_rdata, (i % 2) == 1);
        end

        // Engine lock held across a display burst
        do_reset();
        drv_eng(1'b1, 1'b0, 1'b1, 11'h3FF, 1'b0);
        drv_ed(1'b1, 1'b0, 11'h007, 1'b0);
        #1;
        check("lk_first_gnt", bp.eng_gnt, 1'b1);
        tick();
        check("lk_rvalid", bp.eng_rvalid, 1'b1);
        check("lk_rdata", bp.eng_rdata, 1'b0);
        drv_disp(1'b1, 11'h100);
        drv_eng(1'b1, 1'b1, 1'b0, 11'h3FF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lk_disp_eng_gnt", bp.eng_gnt, 1'b0);
            check("lk_disp_ed_gnt", bp.ed_gnt, 1'b0);
            check("lk_disp_we", bp.mem_we, 1'b0);
            tick();
        end
        drv_disp(1'b0, 11'h0);
        #1;
        check("lk_wr_eng_gnt", bp.eng_gnt, 1'b1);
        check("lk_wr_ed_gnt", bp.ed_gnt, 1'b0);
        check("lk_wr_we", bp.mem_we, 1'b1);
        check("lk_wr_addr", bp.mem_addr, 11'h3FF);
        check("lk_wr_wdata", bp.mem_wdata, 1'b1);
        tick();
        check("lk_wr_no_rvalid", bp.eng_rvalid, 1'b0);
        drv_eng(1'b1, 1'b0, 1'b0, 11'h3FF, 1'b0);
        #1;
        check("lk_rel_ed_gnt", bp.ed_gnt, 1'b1);
        tick();
        drv_ed(1'b0, 1'b0, 11'h0, 1'b0);
        #1;
        check("lk_rb_gnt", bp.eng_gnt, 1'b1);
        tick();
        check("lk_rb_rvalid", bp.eng_rvalid, 1'b1);
        check("lk_rb_rdata", bp.eng_rdata, 1'b1);

        // Starvation boost with the pointer favouring the editor
        do_reset();
        drv_eng(1'b1, 1'b0, 1'b0, 11'h011, 1'b0);
        drv_ed(1'b1, 1'b0, 11'h007, 1'b0);
        #1;
        check("sv_first_gnt", bp.eng_gnt, 1'b1);
        tick();
        drv_disp(1'b1, 11'h040);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("sv_deny", bp.eng_gnt, 1'b0);
            tick();
            check("sv_starved", bp.eng_starved, k == 3);
        end
        drv_disp(1'b0, 11'h0);
        #1;
        check("sv_boost_eng_gnt", bp.eng_gnt, 1'b1);
        check("sv_boost_ed_gnt", bp.ed_gnt, 1'b0);
        tick();
        check("sv_cleared", bp.eng_starved, 1'b0);
        #1;
        check("sv_ptr_kept", bp.ed_gnt, 1'b1);
        tick();

        // Reset asserted while an editor read is granted
        do_reset();
        drv_eng(1'b1, 1'b0, 1'b0, 11'h011, 1'b0);
        #1;
        check("mr_eng_gnt", bp.eng_gnt, 1'b1);
        tick();
        drv_eng(1'b0, 1'b0, 1'b0, 11'h0, 1'b0);
        drv_ed(1'b1, 1'b0, 11'h007, 1'b0);
        #1;
        check("mr_ed_gnt", bp.ed_gnt, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_rst_ed_gnt", bp.ed_gnt, 1'b0);
        check("mr_rst_mem_en", bp.mem_en, 1'b0);
        tick();
        check("mr_rvalid_in_rst", bp.ed_rvalid, 1'b0);
        drv_ed(1'b0, 1'b0, 11'h0, 1'b0);
        rst_n = 1'b1;
        tick();
        check("mr_rvalid_after", bp.ed_rvalid, 1'b0);
        drv_eng(1'b1, 1'b0, 1'b0, 11'h011, 1'b0);
        drv_ed(1'b1, 1'b0, 11'h007, 1'b0);
        #1;
        check("mr_ptr_eng_gnt", bp.eng_gnt, 1'b1);
        check("mr_ptr_ed_gnt", bp.ed_gnt, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
